// File: rtl/lb_pkg.sv
// Shared config-register layout and mode encoding for the multi-tap line buffer.
// Field positions live here so the RTL and software headers agree on one source.
package lb_pkg;

  typedef enum logic [1:0] {
    LB_MODE_LINEBUF = 2'b00
  } lb_mode_e;

  localparam int CFG_REG_W           = 16;
  localparam int CFG_MODE_LSB        = 0;
  localparam int CFG_MODE_W          = 2;
  localparam int CFG_EN_BIT          = 2;
  localparam int CFG_DEPTH_LSB       = 3;
  localparam int CFG_DEPTH_W         = 13;
  localparam int LB_CFG_ADDR_DEFAULT = 0;

endpackage

// File: rtl/lb_row_ram.sv
// One line-buffer row: flop array with combinational read and synchronous write at the same address.
// Read returns the old word on a write cycle; no flow control, the caller sequences the writes.
module lb_row_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 64,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately left unreset; fill counters mask stale words.
  logic [DATA_WIDTH-1:0] mem [MAX_DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/linebuffer_multitap.sv
// Cascaded NUM_TAPS line buffer of runtime depth D; tap k is the input delayed by (k+1)*D writes, 1-cycle output latency.
// No backpressure: every enabled write is accepted; clk_en freezes the datapath while the config path stays live.
module linebuffer_multitap
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DEPTH  = 64,
  parameter int NUM_TAPS   = 2,
  parameter int CFG_ADDR   = LB_CFG_ADDR_DEFAULT
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           flush,
  input  logic                           config_en,
  input  logic                           config_read,
  input  logic [31:0]                    config_addr,
  input  logic [31:0]                    config_data,
  output logic [31:0]                    read_data,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           wen_in,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_TAPS-1:0]            valid_out
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam logic [CFG_DEPTH_W-1:0] MAX_D = CFG_DEPTH_W'(MAX_DEPTH);

  logic [CFG_REG_W-1:0]   cfg_q;
  logic [CFG_DEPTH_W-1:0] depth_raw;
  logic [CW-1:0]          depth;
  logic [CW-1:0]          wp_last;
  logic [AW-1:0]          wp;
  logic                   cfg_hit;
  logic                   cfg_wr;
  logic                   active;
  logic                   clear;
  logic                   accept;
  logic [CW-1:0]          cnt       [NUM_TAPS];
  logic [DATA_WIDTH-1:0]  ev        [NUM_TAPS];
  logic [NUM_TAPS-1:0]    prev_full;
  logic                   unused_cfg_bits;

  assign unused_cfg_bits = ^{config_addr[31:8], config_data[31:CFG_REG_W]};

  assign cfg_hit   = (config_addr[7:0] == 8'(CFG_ADDR));
  assign cfg_wr    = config_en & cfg_hit;
  assign depth_raw = cfg_q[CFG_DEPTH_LSB +: CFG_DEPTH_W];
  assign depth     = (depth_raw > MAX_D) ? CW'(MAX_DEPTH) : depth_raw[CW-1:0];
  assign wp_last   = depth - 1'b1;
  assign active    = (cfg_q[CFG_MODE_LSB +: CFG_MODE_W] == LB_MODE_LINEBUF) &&
                     cfg_q[CFG_EN_BIT] && (depth_raw != '0);

  // A config write restarts the fill exactly like a flush and steals the write slot.
  assign clear  = cfg_wr | (flush & clk_en);
  assign accept = wen_in & clk_en & active & ~clear;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cfg_q     <= '0;
      read_data <= '0;
    end else begin
      if (cfg_wr) begin
        cfg_q <= config_data[CFG_REG_W-1:0];
      end
      if (config_read && cfg_hit) begin
        read_data <= 32'(cfg_q);
      end
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_row
    logic [DATA_WIDTH-1:0] wdata;
    if (k == 0) begin : g_first
      assign wdata        = data_in;
      assign prev_full[k] = 1'b1;
    end else begin : g_next
      assign wdata        = ev[k-1];
      assign prev_full[k] = (cnt[k-1] == depth);
    end

    lb_row_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DEPTH  (MAX_DEPTH),
      .AW         (AW)
    ) u_row (
      .clk   (clk_in),
      .we    (accept),
      .addr  (wp),
      .wdata (wdata),
      .rdata (ev[k])
    );
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      valid_out <= '0;
      data_out  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        cnt[k] <= '0;
      end
    end else if (clear) begin
      wp        <= '0;
      valid_out <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        cnt[k] <= '0;
      end
    end else if (clk_en) begin
      if (accept) begin
        wp <= (CW'(wp) == wp_last) ? '0 : wp + 1'b1;
        for (int k = 0; k < NUM_TAPS; k++) begin
          data_out[k*DATA_WIDTH +: DATA_WIDTH] <= ev[k];
          valid_out[k] <= (cnt[k] == depth);
          // Row k only starts counting once the row feeding it is full.
          if ((cnt[k] != depth) && prev_full[k]) begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end
      end else begin
        valid_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_linebuffer_multitap.sv
// Randomized bench for linebuffer_multitap against a history-queue model of the tap delays.
module tb_linebuffer_multitap;

  localparam int W  = 16;
  localparam int MD = 64;
  localparam int NT = 2;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          clk_en = 1'b0;
  logic          flush = 1'b0;
  logic          config_en = 1'b0;
  logic          config_read = 1'b0;
  logic [31:0]   config_addr = '0;
  logic [31:0]   config_data = '0;
  logic [31:0]   read_data;
  logic [W-1:0]  data_in = '0;
  logic          wen_in = 1'b0;
  logic [NT*W-1:0] data_out;
  logic [NT-1:0] valid_out;

  linebuffer_multitap #(
    .DATA_WIDTH (W),
    .MAX_DEPTH  (MD),
    .NUM_TAPS   (NT),
    .CFG_ADDR   (0)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .clk_en      (clk_en),
    .flush       (flush),
    .config_en   (config_en),
    .config_read (config_read),
    .config_addr (config_addr),
    .config_data (config_data),
    .read_data   (read_data),
    .data_in     (data_in),
    .wen_in      (wen_in),
    .data_out    (data_out),
    .valid_out   (valid_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Model: tap k on accepted write n (since last restart) shows write n-(k+1)*D.
  logic [15:0]  m_cfg;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [$];
  logic [NT-1:0] m_vld;
  logic [W-1:0] m_dat   [NT];
  bit           m_known [NT];
  logic [W-1:0] next_din = 1;

  function automatic int m_depth();
    int raw;
    raw = int'(m_cfg[15:3]);
    if (m_cfg[1:0] != 2'b00 || !m_cfg[2] || raw == 0) return 0;
    return (raw > MD) ? MD : raw;
  endfunction

  task automatic model_reset();
    m_cfg = '0;
    m_rd  = '0;
    m_vld = '0;
    hist.delete();
    for (int k = 0; k < NT; k++) begin
      m_dat[k]   = '0;
      m_known[k] = 1'b1;
    end
  endtask

  task automatic model_edge(output bit acc);
    bit cw, rdm;
    int d, n;
    acc = 1'b0;
    cw  = config_en && (config_addr[7:0] == 8'h00);
    rdm = config_read && (config_addr[7:0] == 8'h00);
    if (rdm) m_rd = {16'h0, m_cfg};
    if (cw) begin
      m_cfg = config_data[15:0];
      hist.delete();
      m_vld = '0;
    end else if (clk_en && flush) begin
      hist.delete();
      m_vld = '0;
    end else if (clk_en) begin
      d = m_depth();
      if (wen_in && d != 0) begin
        acc = 1'b1;
        hist.push_back(data_in);
        n = hist.size();
        for (int k = 0; k < NT; k++) begin
          if (n > (k + 1) * d) begin
            m_vld[k]   = 1'b1;
            m_dat[k]   = hist[n - 1 - (k + 1) * d];
            m_known[k] = 1'b1;
          end else begin
            m_vld[k]   = 1'b0;
            m_known[k] = 1'b0;
          end
        end
      end else begin
        m_vld = '0;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(valid_out), 32'(m_vld));
    check("rdata", read_data, m_rd);
    for (int k = 0; k < NT; k++) begin
      if (m_known[k]) check($sformatf("tap%0d", k), 32'(data_out[k*W +: W]), 32'(m_dat[k]));
    end
  endtask

  task automatic cyc(input bit wen, input bit en, input bit fl);
    bit acc;
    data_in = next_din;
    wen_in  = wen;
    clk_en  = en;
    flush   = fl;
    @(posedge clk_in);
    #1;
    model_edge(acc);
    compare_all();
    if (acc) next_din = next_din + 1'b1;
    config_en   = 1'b0;
    config_read = 1'b0;
    config_addr = '0;
  endtask

  task automatic cfg_write(input logic [31:0] dat, input logic [7:0] addr, input bit wen);
    config_en   = 1'b1;
    config_addr = {24'h0, addr};
    config_data = dat;
    cyc(wen, 1'b1, 1'b0);
  endtask

  task automatic cfg_read();
    config_read = 1'b1;
    config_addr = '0;
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  logic [W-1:0] first_val;

  initial begin
    model_reset();
    #12;
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_rdata", read_data, 32'h0);
    reset = 1'b0;

    // contiguous fill at D=15
    cfg_write(32'h7C, 8'h00, 1'b0);
    for (int i = 1; i <= 45; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i == 15) check("pre_first_valid", 32'(valid_out), 32'h0);
      if (i == 16) begin
        check("t0_first_vld", 32'(valid_out), 32'h1);
        check("t0_first_val", 32'(data_out[0 +: W]), 32'd1);
      end
      if (i == 31) begin
        check("t1_first_vld", 32'(valid_out), 32'h3);
        check("t1_first_val", 32'(data_out[W +: W]), 32'd1);
        check("t0_at_31", 32'(data_out[0 +: W]), 32'd16);
      end
    end

    // random gaps
    for (int i = 0; i < 80; i++) cyc(1'(($urandom_range(0, 3)) != 0), 1'b1, 1'b0);

    // flush pulse with a write attempted during it
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      check("flush_vld", 32'(valid_out), 32'h0);
    end
    next_din = 101;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i == 16) check("flush_t0_first", 32'(data_out[0 +: W]), 32'd101);
    end

    // clock-enable freeze
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);

    // config read-back and ignored foreign address
    cfg_read();
    cyc(1'b0, 1'b1, 1'b0);
    check("rd_d15", read_data, 32'h7C);
    cfg_write(32'h0, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);

    // oversized depth clamps to MAX_DEPTH
    cfg_write(32'hFFFC, 8'h00, 1'b0);
    cfg_read();
    check("rd_d8191", read_data, 32'h0000FFFC);
    for (int i = 1; i <= 140; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      if (i == 64) check("clamp_pre", 32'(valid_out), 32'h0);
      if (i == 65) check("clamp_first", 32'(valid_out), 32'h1);
    end

    // zero depth is inactive
    cfg_write(32'h4, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
    check("d0_vld", 32'(valid_out), 32'h0);

    // config concurrent with a write
    cfg_write(32'h7C, 8'h00, 1'b1);
    first_val = next_din;
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 1'b0);
    check("cfg_drop_t0", 32'(data_out[0 +: W]), 32'(first_val));

    // async reset mid-stream
    cfg_write(32'h7C, 8'h00, 1'b0);
    for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    model_reset();
    check("amid_vld", 32'(valid_out), 32'h0);
    check("amid_data", 32'(data_out), 32'h0);
    check("amid_rdata", read_data, 32'h0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0);
    check("post_rst_vld", 32'(valid_out), 32'h0);
    cfg_write(32'h7C, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'(($urandom_range(0, 1))), 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
